// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoded MIPS instruction descriptors into 32-bit machine words
// and writes them to instruction memory. Optional macro INSTR_ENC_DELAY_SLOT_EN adds a nop after control transfers.

module instr_encoder #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [ADDR_W-1:0] in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_SLT  = 4'd2;
    localparam logic [3:0] K_JR   = 4'd3;
    localparam logic [3:0] K_LW   = 4'd4;
    localparam logic [3:0] K_SW   = 4'd5;
    localparam logic [3:0] K_J    = 4'd6;
    localparam logic [3:0] K_JAL  = 4'd7;
    localparam logic [3:0] K_BEQ  = 4'd8;
    localparam logic [3:0] K_BNE  = 4'd9;
    localparam logic [3:0] K_XORI = 4'd10;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_KIND  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    localparam logic [ADDR_W-1:0] PC_STEP   = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [ADDR_W:0]   PC_STEP_X = {{(ADDR_W-2){1'b0}}, 3'b100};

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] field);
        return {op, field};
    endfunction

    state_t state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [15:0]       count_r, count_s;
    logic              err_r, err_s;
    logic [1:0]        err_code_r, err_code_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              in_ready_r, in_ready_s;
    logic              last_pend_r, last_pend_s;
    logic              accept_s;

    logic [31:0]         pc32_s, tgt32_s, pc4_32_s;
    logic [ADDR_W:0]     diff_s;
    logic signed [ADDR_W:0] off_s;
    logic                off_ok_s, aligned_s, region_ok_s;
    logic [31:0]         word_s;
    logic [1:0]          code_s;

`ifdef INSTR_ENC_DELAY_SLOT_EN
    logic pad_pend_r, pad_pend_s;
    logic xfer_s;

    // Control transfers that must be followed by a delay-slot nop
    always_comb begin
        xfer_s = (in_kind == K_JR) || (in_kind == K_J) || (in_kind == K_JAL) ||
                 (in_kind == K_BEQ) || (in_kind == K_BNE);
    end
`endif

    // Encode the presented descriptor against the current pc and classify errors
    always_comb begin
        pc32_s      = 32'(pc_r);
        tgt32_s     = 32'(in_target);
        pc4_32_s    = pc32_s + 32'd4;
        // Offset is formed one bit wider than the address so wrap cannot fake an in-range value
        diff_s      = {1'b0, in_target} - ({1'b0, pc_r} + PC_STEP_X);
        off_s       = $signed(diff_s) >>> 2;
        off_ok_s    = (&off_s[ADDR_W:15]) | ~(|off_s[ADDR_W:15]);
        aligned_s   = (tgt32_s[1:0] == 2'b00);
        region_ok_s = ((tgt32_s ^ pc4_32_s) & 32'hF000_0000) == 32'h0000_0000;
        word_s      = 32'h0000_0000;
        code_s      = ERR_NONE;
        case (in_kind)
            K_ADD:  word_s = enc_r(in_rs, in_rt, in_rd, F_ADD);
            K_SUB:  word_s = enc_r(in_rs, in_rt, in_rd, F_SUB);
            K_SLT:  word_s = enc_r(in_rs, in_rt, in_rd, F_SLT);
            K_JR:   word_s = enc_r(in_rs, 5'd0, 5'd0, F_JR);
            K_LW:   word_s = enc_i(OP_LW, in_rs, in_rt, in_imm);
            K_SW:   word_s = enc_i(OP_SW, in_rs, in_rt, in_imm);
            K_XORI: word_s = enc_i(OP_XORI, in_rs, in_rt, in_imm);
            K_J, K_JAL: begin
                word_s = enc_j((in_kind == K_J) ? OP_J : OP_JAL, tgt32_s[27:2]);
                if (!aligned_s) begin
                    code_s = ERR_ALIGN;
                end else if (!region_ok_s) begin
                    code_s = ERR_RANGE;
                end else begin
                    code_s = ERR_NONE;
                end
            end
            K_BEQ, K_BNE: begin
                word_s = enc_i((in_kind == K_BEQ) ? OP_BEQ : OP_BNE, in_rs, in_rt, off_s[15:0]);
                if (!aligned_s) begin
                    code_s = ERR_ALIGN;
                end else if (!off_ok_s) begin
                    code_s = ERR_RANGE;
                end else begin
                    code_s = ERR_NONE;
                end
            end
            default: code_s = ERR_KIND;
        endcase
    end

    // Sequencing: start/run/done/error transitions and the memory write stream
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        count_s     = count_r;
        err_s       = err_r;
        err_code_s  = err_code_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        last_pend_s = last_pend_r;
`ifdef INSTR_ENC_DELAY_SLOT_EN
        pad_pend_s  = pad_pend_r;
`endif
        accept_s    = in_valid & in_ready_r;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_s     = ST_RUN;
                    pc_s        = base_addr;
                    count_s     = 16'd0;
                    err_s       = 1'b0;
                    err_code_s  = ERR_NONE;
                    last_pend_s = 1'b0;
`ifdef INSTR_ENC_DELAY_SLOT_EN
                    pad_pend_s  = 1'b0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
`ifdef INSTR_ENC_DELAY_SLOT_EN
                if (pad_pend_r) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = pc_r;
                    mem_wdata_s = 32'h0000_0000;
                    pc_s        = pc_r + PC_STEP;
                    count_s     = count_r + 16'd1;
                    pad_pend_s  = 1'b0;
                end else
`endif
                if (last_pend_r) begin
                    state_s     = ST_DONE;
                    last_pend_s = 1'b0;
                end else if (accept_s) begin
                    if (code_s != ERR_NONE) begin
                        state_s    = ST_ERR;
                        err_s      = 1'b1;
                        err_code_s = code_s;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = pc_r;
                        mem_wdata_s = word_s;
                        pc_s        = pc_r + PC_STEP;
                        count_s     = count_r + 16'd1;
                        last_pend_s = in_last;
`ifdef INSTR_ENC_DELAY_SLOT_EN
                        pad_pend_s  = xfer_s;
`endif
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
`ifdef INSTR_ENC_DELAY_SLOT_EN
        in_ready_s = (state_s == ST_RUN) && !last_pend_s && !pad_pend_s;
`else
        in_ready_s = (state_s == ST_RUN) && !last_pend_s;
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= '0;
            count_r     <= 16'd0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            last_pend_r <= 1'b0;
`ifdef INSTR_ENC_DELAY_SLOT_EN
            pad_pend_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            count_r     <= count_s;
            err_r       <= err_s;
            err_code_r  <= err_code_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            in_ready_r  <= in_ready_s;
            last_pend_r <= last_pend_s;
`ifdef INSTR_ENC_DELAY_SLOT_EN
            pad_pend_r  <= pad_pend_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign count     = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized programs
// checked against a field-level reference encoder.

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    instr_encoder #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int rs, input int rt, input int rd,
                         input int imm, input logic [31:0] tgt, input logic last);
        in_valid  = 1'b1;
        in_kind   = 4'(k);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic do_start(input logic [31:0] b);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    // Reference encoder: builds words from the MIPS field layout with plain arithmetic
    function automatic void model_enc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm,
                                      input logic [31:0] tgt, input logic [31:0] pc,
                                      output logic [31:0] w, output int code);
        longint d, off;
        logic [31:0] pc4;
        logic [31:0] rsf, rtf, rdf;
        w = 32'h0; code = 0; pc4 = pc + 32'd4;
        rsf = 32'(rs) << 21; rtf = 32'(rt) << 16; rdf = 32'(rd) << 11;
        case (k)
            4'd0: w = rsf | rtf | rdf | 32'd32;
            4'd1: w = rsf | rtf | rdf | 32'd34;
            4'd2: w = rsf | rtf | rdf | 32'd42;
            4'd3: w = rsf | 32'd8;
            4'd4: w = (32'd35 << 26) | rsf | rtf | 32'(imm);
            4'd5: w = (32'd43 << 26) | rsf | rtf | 32'(imm);
            4'd10: w = (32'd14 << 26) | rsf | rtf | 32'(imm);
            4'd6, 4'd7: begin
                if (tgt % 4 != 0) code = 2;
                else if (tgt[31:28] != pc4[31:28]) code = 3;
                else w = (((k == 4'd6) ? 32'd2 : 32'd3) << 26) | ((tgt % 32'h1000_0000) / 4);
            end
            4'd8, 4'd9: begin
                if (tgt % 4 != 0) code = 2;
                else begin
                    d = longint'(tgt) - (longint'(pc) + 4);
                    off = d / 4;
                    if (off < -32768 || off > 32767) code = 3;
                    else w = (((k == 4'd8) ? 32'd4 : 32'd5) << 26) | rsf | rtf | 32'(off & 64'hFFFF);
                end
            end
            default: code = 1;
        endcase
    endfunction

    task automatic test_reset();
        start = 0; in_valid = 0; in_kind = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_imm = 0; in_target = 0; in_last = 0; base_addr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if ({mem_we, in_ready, busy, done, err, err_code} !== 7'd0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {mem_we, in_ready, busy, done, err, err_code}); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %h want 0", count); end
        checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin errors++; $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy %b ready %b want 0 0", busy, in_ready); end
    endtask

    task automatic test_add_done();
        bit seen;
        do_start(32'h0);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || count !== 16'd0) begin errors++; $display("FAIL add_start got busy %b ready %b count %0d want 1 1 0", busy, in_ready, count); end
        drive(0, 1, 2, 3, 0, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL add_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0022_1820) begin errors++; $display("FAIL add_data got %h want 00221820", mem_wdata); end
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL add_count got %0d want 1", count); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1) begin seen = 1; break; end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL add_done got no pulse want pulse"); end
        checks++; if (mem_we !== 1'b0 || count !== 16'd1) begin errors++; $display("FAIL add_done_state got we %b count %0d want 0 1", mem_we, count); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_idle got done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_back_to_back();
        do_start(32'h100);
        drive(4, 29, 8, 0, 4, 32'h0, 1'b0);
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h8FA8_0004) begin errors++; $display("FAIL lw_word got we %b addr %h data %h want 1 100 8fa80004", mem_we, mem_addr, mem_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_ready got %b want 1", in_ready); end
        drive(5, 29, 9, 0, 8, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'hAFA9_0008) begin errors++; $display("FAIL sw_word got we %b addr %h data %h want 1 104 afa90008", mem_we, mem_addr, mem_wdata); end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        checks++; if (done !== 1'b1 || count !== 16'd2) begin errors++; $display("FAIL sw_done got done %b count %0d want 1 2", done, count); end
        tick();
    endtask

    task automatic test_branch();
        do_start(32'h10);
        drive(8, 1, 2, 0, 0, 32'h8, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h1022_FFFD) begin errors++; $display("FAIL beq_word got we %b addr %h data %h want 1 10 1022fffd", mem_we, mem_addr, mem_wdata); end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL beq_done got %b want 1", done); end
        tick();
        do_start(32'h10);
        drive(9, 1, 2, 0, 0, 32'h0002_0014, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bne_range_we got %b want 0", mem_we); end
        checks++; if (err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL bne_range_err got %b code %0d want 1 3", err, err_code); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL bne_range_state got ready %b busy %b count %0d want 0 0 0", in_ready, busy, count); end
    endtask

    task automatic test_jal_align();
        do_start(32'h0040_0000);
        drive(7, 0, 0, 0, 0, 32'h0040_0020, 1'b0);
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h0C10_0008) begin errors++; $display("FAIL jal_word got we %b addr %h data %h want 1 00400000 0c100008", mem_we, mem_addr, mem_wdata); end
`ifdef INSTR_ENC_DELAY_SLOT_EN
        in_valid = 1'b0;
        tick();
`endif
        drive(8, 0, 0, 0, 0, 32'h2, 1'b1);
        tick();
        checks++; if (err !== 1'b1 || err_code !== 2'd2 || mem_we !== 1'b0) begin errors++; $display("FAIL beq_align got err %b code %0d we %b want 1 2 0", err, err_code, mem_we); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL err_hold got ready %b we %b err %b want 0 0 1", in_ready, mem_we, err); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal_restart();
        do_start(32'h0);
        checks++; if (err !== 1'b0 || count !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart1 got err %b count %0d busy %b want 0 0 1", err, count, busy); end
        drive(12, 1, 2, 3, 0, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || err_code !== 2'd1 || mem_we !== 1'b0) begin errors++; $display("FAIL illegal_kind got err %b code %0d we %b want 1 1 0", err, err_code, mem_we); end
        do_start(32'h40);
        checks++; if (err !== 1'b0 || count !== 16'd0 || busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL restart2 got err %b count %0d busy %b ready %b want 0 0 1 1", err, count, busy, in_ready); end
        drive(1, 4, 5, 6, 0, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h0085_3022) begin errors++; $display("FAIL sub_after_restart got addr %h data %h want 40 00853022", mem_addr, mem_wdata); end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        tick();
    endtask

`ifdef INSTR_ENC_DELAY_SLOT_EN
    task automatic test_delay_slot();
        do_start(32'h0);
        drive(6, 0, 0, 0, 0, 32'h40, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0800_0010 || in_ready !== 1'b0) begin errors++; $display("FAIL ds_j got addr %h data %h ready %b want 0 08000010 0", mem_addr, mem_wdata, in_ready); end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h0 || count !== 16'd2) begin errors++; $display("FAIL ds_pad got we %b addr %h data %h count %0d want 1 4 0 2", mem_we, mem_addr, mem_wdata, count); end
        drive(0, 1, 2, 3, 0, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_addr !== 32'h8 || mem_wdata !== 32'h0022_1820 || count !== 16'd3) begin errors++; $display("FAIL ds_add got addr %h data %h count %0d want 8 00221820 3", mem_addr, mem_wdata, count); end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] mpc, base, w, tgt;
        logic [3:0]  k;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int mcnt, len, sent, code, exp_code;
        bit errored, pad_wait, nxt_pad, acc, seen;
        wr_t e;
        for (int p = 0; p < 40; p++) begin
            len  = $urandom_range(1, 8);
            base = (p % 2 == 0) ? ($urandom & 32'h0000_FFFC) : ($urandom & 32'hFFFF_FFFC);
            do_start(base);
            mpc = base; mcnt = 0; sent = 0; errored = 0; pad_wait = 0; exp_code = 0;
            exp_q.delete();
            for (int cyc = 0; cyc < 200 && sent < len && !errored; cyc++) begin
                if (cyc == 0 || acc) begin
                    k = ($urandom_range(0, 99) < 4) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
                    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
                    if (k == 4'd8 || k == 4'd9) tgt = mpc + 32'd4 + 32'($urandom_range(0, 32'h50000)) - 32'h28000;
                    else if ((k == 4'd6 || k == 4'd7) && $urandom_range(0, 4) != 0) tgt = ((mpc + 32'd4) & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC);
                    else tgt = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
                end
                drive(k, rs, rt, rd, imm, tgt, 1'(sent == len - 1));
                in_valid = ($urandom_range(0, 3) != 0);
                checks++; if (in_ready !== !pad_wait) begin errors++; $display("FAIL rnd_ready got %b want %b", in_ready, !pad_wait); end
                acc = in_valid && in_ready;
                nxt_pad = 0;
                if (acc) begin
                    model_enc(k, rs, rt, rd, imm, tgt, mpc, w, code);
                    if (code != 0) begin
                        errored = 1; exp_code = code;
                    end else begin
                        exp_q.push_back('{a: mpc, d: w});
                        mpc = mpc + 32'd4; mcnt++;
`ifdef INSTR_ENC_DELAY_SLOT_EN
                        if (k == 4'd3 || k == 4'd6 || k == 4'd7 || k == 4'd8 || k == 4'd9) begin
                            exp_q.push_back('{a: mpc, d: 32'h0});
                            mpc = mpc + 32'd4; mcnt++; nxt_pad = 1;
                        end
`endif
                    end
                    sent++;
                end
                tick();
                pad_wait = nxt_pad;
                if (errored) begin
                    checks++; if (err !== 1'b1 || err_code !== 2'(exp_code) || mem_we !== 1'b0) begin errors++; $display("FAIL rnd_err got err %b code %0d we %b want 1 %0d 0", err, err_code, mem_we, exp_code); end
                end else if (mem_we === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra_write got addr %h want none", mem_addr); end
                    else begin
                        e = exp_q.pop_front();
                        if (mem_addr !== e.a || mem_wdata !== e.d) begin errors++; $display("FAIL rnd_write got %h:%h want %h:%h", mem_addr, mem_wdata, e.a, e.d); end
                    end
                end
            end
            in_valid = 1'b0;
            if (!errored) begin
                checks++; if (sent < len) begin errors++; $display("FAIL rnd_timeout got %0d sent want %0d", sent, len); end
                seen = 0;
                for (int c = 0; c < 10; c++) begin
                    if (done === 1'b1) begin seen = 1; break; end
                    tick();
                    if (mem_we === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra_write got addr %h want none", mem_addr); end
                        else begin
                            e = exp_q.pop_front();
                            if (mem_addr !== e.a || mem_wdata !== e.d) begin errors++; $display("FAIL rnd_write got %h:%h want %h:%h", mem_addr, mem_wdata, e.a, e.d); end
                        end
                    end
                end
                checks++; if (!seen || exp_q.size() != 0) begin errors++; $display("FAIL rnd_done got done %b pending %0d want 1 0", seen, exp_q.size()); end
                checks++; if (count !== 16'(mcnt)) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, mcnt); end
                tick();
            end
        end
    endtask

    task automatic test_mid_reset();
        do_start(32'h200);
        drive(0, 7, 8, 9, 0, 32'h0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_we, in_ready, busy, done, err, err_code} !== 7'd0) begin errors++; $display("FAIL midrst_ctrl got %b want 0", {mem_we, in_ready, busy, done, err, err_code}); end
        checks++; if ({mem_addr, mem_wdata, count} !== 80'd0) begin errors++; $display("FAIL midrst_data got %h want 0", {mem_addr, mem_wdata, count}); end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL midrst_after got we %b busy %b count %0d want 0 0 0", mem_we, busy, count); end
    endtask

    initial begin
        test_reset();
        test_add_done();
        test_back_to_back();
        test_branch();
        test_jal_align();
        test_illegal_restart();
`ifdef INSTR_ENC_DELAY_SLOT_EN
        test_delay_slot();
`endif
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoding counterpart of the MIPS control decoder: converts a stream of decoded instruction descriptors into 32-bit MIPS machine words.
- Writes the words sequentially into instruction memory starting at a programmable base address.
- Used by test infrastructure and the boot loader to build programs for the single-cycle CPU without an external assembler.
- Computes PC-relative branch offsets and jump-region fields itself, and flags unencodable inputs.

Parameters:
ADDR_W, 32, byte-address width of the memory write port and target input (16..32).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; loads pc from base_addr, clears err/count, enters RUN.
base_addr  in  ADDR_W  byte address of the first word; sampled on start.
in_valid  in  1  descriptor valid.
in_ready  out  1  encoder accepts a descriptor this cycle.
in_kind  in  4  0 ADD, 1 SUB, 2 SLT, 3 JR, 4 LW, 5 SW, 6 J, 7 JAL, 8 BEQ, 9 BNE, 10 XORI.
in_rs, in_rt, in_rd  in  5 each  register fields.
in_imm  in  16  immediate for LW/SW/XORI.
in_target  in  ADDR_W  byte target for J/JAL/BEQ/BNE.
in_last  in  1  marks the final descriptor of the program.
mem_we  out  1  instruction memory write strobe.
mem_addr  out  ADDR_W  write byte address.
mem_wdata  out  32  encoded word.
busy  out  1  state is RUN.
done  out  1  one-cycle pulse after the last word is written.
err  out  1  sticky error; cleared only by start or reset.
err_code  out  2  1 illegal kind, 2 unaligned target, 3 out of range.
count  out  16  words written since start; wraps at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc, count, err_code, mem_addr, mem_wdata = 0; mem_we, in_ready, busy, done, err = 0. Mid-operation reset discards any pending word.
- States: IDLE, RUN, DONE, ERR.
  - IDLE -> RUN on start.
  - RUN -> DONE after the write of the in_last word.
  - DONE -> IDLE after 1 cycle; done=1 during DONE.
  - RUN -> ERR on any encode error.
  - ERR -> RUN on start.
- start is ignored in RUN and DONE.
- in_ready = (state==RUN) and no pad pending.
- Accept = in_valid & in_ready.
- Latency: descriptor accepted in cycle N produces mem_we=1 in cycle N+1 with mem_addr = pc at acceptance; pc += 4, count += 1. Throughput: one word per cycle.
- mem_we is low in every cycle with no write; mem_addr/mem_wdata hold their last values.
- Encodings (fields op|rs|rt|rd|shamt|funct):
  - ADD/SUB/SLT/JR: op 0x00, funct 0x20/0x22/0x2A/0x08, shamt 0. JR writes only rs; rt = rd = 0.
  - LW: op 0x23. SW: op 0x2B. XORI: op 0x0E. Each is rs|rt|imm.
  - J: op 0x02. JAL: op 0x03. Word = op|target[27:2].
  - BEQ: op 0x04. BNE: op 0x05. Word = rs|rt|off, where off = (target - (pc+4)) >>> 2, computed signed at ADDR_W+1 bits.
  - For ADDR_W < 32, target/pc zero-extend to 32 bits before encoding.
- Errors are checked at accept; the failing word is never written:
  - in_kind > 10 -> code 1.
  - J/JAL/BEQ/BNE with target[1:0] != 0 -> code 2.
  - Branch off outside -32768..32767 -> code 3.
  - J/JAL with target[31:28] != (pc+4)[31:28] -> code 3.
  - On error: err=1 and state ERR from N+1; in_ready=0.
- pc wraps modulo 2^ADDR_W silently.
- in_last on an erroring descriptor: ERR takes priority; no done.

Optional Feature:
- Macro: INSTR_ENC_DELAY_SLOT_EN.
- Defined: after each J/JAL/JR/BEQ/BNE word, the encoder writes 0x00000000 at the next pc in the following cycle.
  - in_ready=0 during that pad cycle; pad advances pc and count.
  - done asserts after the pad when the branch was last.
  - Branch offsets use the actual pc, pads included.
- Undefined: no pads are written; pad logic is absent.

Test Plan:
- start base 0; ADD rs1 rt2 rd3 last -> cycle+1 mem_we, addr 0x0, data 0x00221820; then done pulse, count=1.
- LW rs29 rt8 imm 4 at base 0x100 -> addr 0x100, data 0x8FA80004; next back-to-back SW writes addr 0x104 the following cycle.
- Base 0x10, BEQ rs1 rt2 target 0x8 -> data 0x1022FFFD. BNE target 0x20014 at pc 0x10 -> err=1, err_code=3, no mem_we.
- Base 0x00400000, JAL target 0x00400020 -> 0x0C100008. BEQ target 0x2 -> err_code 2, in_ready=0 until start.
- in_kind 12 -> err_code 1; then start -> err=0, count=0, RUN. Assert rst_n low mid-stream -> all outputs 0 immediately.
- With INSTR_ENC_DELAY_SLOT_EN: J at base 0 then ADD -> words at 0x0 (J), 0x4 (0x00000000), 0x8 (ADD); count=3.
